// File: rtl/rf_pkg.sv
// Shared register-file types and constants for the CPU write-back path.
package rf_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_REG_AW   = 5;
  localparam int RF_NUM_REGS = 1 << RF_REG_AW;
  localparam int RF_ZERO_REG = 0;

  typedef logic [RF_REG_AW-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  // Round-robin pointer: which requester wins when both are valid.
  typedef enum logic {
    RR_REQ0 = 1'b0,
    RR_REQ1 = 1'b1
  } rr_sel_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: marks destinations with in-flight writes and raises
// stall when a decode source register is still pending.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int REG_AW = RF_REG_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              set_valid,
  input  logic [REG_AW-1:0] set_reg,
  input  logic              clr_valid,
  input  logic [REG_AW-1:0] clr_reg,
  input  logic [REG_AW-1:0] rd_reg1,
  input  logic [REG_AW-1:0] rd_reg2,
  output logic              stall
);

  localparam int NUM_REGS = 1 << REG_AW;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Clear is applied before set so a same-edge allocation of the register
  // being written keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (clr_valid) busy_nxt[clr_reg] = 1'b0;
    if (set_valid) busy_nxt[set_reg] = 1'b1;
    busy_nxt[RF_ZERO_REG] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign stall = busy[rd_reg1] | busy[rd_reg2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register-file write port.
// Optional busy-bit scoreboard enabled by defining RF_WB_SCOREBOARD_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int REG_AW = RF_REG_AW
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [REG_AW-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [REG_AW-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              W,
  output logic [REG_AW-1:0] W_reg,
  output logic [DATA_W-1:0] W_data,
  input  logic              alloc_valid,
  input  logic [REG_AW-1:0] alloc_reg,
  input  logic [REG_AW-1:0] rd_reg1,
  input  logic [REG_AW-1:0] rd_reg2,
  output logic              stall
);

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(RF_ZERO_REG);

  rr_sel_e           rr_ptr;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic              xfer_wr;
  logic [REG_AW-1:0] xfer_reg;
  logic [DATA_W-1:0] xfer_data;

  // Readies are masked during reset so no transfer can land on a reset edge.
  always_comb begin
    grant0    = 1'b0;
    grant1    = 1'b0;
    if (!RST) begin
      grant0 = req0_valid && (!req1_valid || rr_ptr == RR_REQ0);
      grant1 = req1_valid && (!req0_valid || rr_ptr == RR_REQ1);
    end
    xfer      = grant0 | grant1;
    xfer_reg  = grant1 ? req1_reg  : req0_reg;
    xfer_data = grant1 ? req1_data : req0_data;
    xfer_wr   = xfer && (xfer_reg != ZERO_REG);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr <= RR_REQ0;
      W      <= 1'b0;
      W_reg  <= '0;
      W_data <= '0;
    end else begin
      W <= xfer_wr;
      if (xfer_wr) begin
        W_reg  <= xfer_reg;
        W_data <= xfer_data;
      end
      if (grant0)      rr_ptr <= RR_REQ1;
      else if (grant1) rr_ptr <= RR_REQ0;
    end
  end

`ifdef RF_WB_SCOREBOARD_EN
  rf_scoreboard #(
    .REG_AW (REG_AW)
  ) u_scoreboard (
    .CLK       (CLK),
    .RST       (RST),
    .set_valid (alloc_valid && (alloc_reg != ZERO_REG)),
    .set_reg   (alloc_reg),
    .clr_valid (xfer_wr),
    .clr_reg   (xfer_reg),
    .rd_reg1   (rd_reg1),
    .rd_reg2   (rd_reg2),
    .stall     (stall)
  );
`else
  logic unused_sb;
  assign unused_sb = ^{alloc_valid, alloc_reg, rd_reg1, rd_reg2};
  assign stall     = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed plan steps then random traffic
// compared against a behavioural model of grants, write port and busy bits.
module tb_rf_wb_arbiter;

`ifdef RF_WB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        W;
  logic [4:0]  W_reg;
  logic [31:0] W_data;
  logic        alloc_valid;
  logic [4:0]  alloc_reg, rd_reg1, rd_reg2;
  logic        stall;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          ptr_m;
  bit          busy_m [32];
  bit          w_m;
  logic [4:0]  wreg_m;
  logic [31:0] wdata_m;
  int          g_last;

  always #5 CLK = ~CLK;

  rf_wb_arbiter #(
    .DATA_W (32),
    .REG_AW (5)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_reg   (req0_reg),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_reg   (req1_reg),
    .req1_data  (req1_data),
    .W          (W),
    .W_reg      (W_reg),
    .W_data     (W_data),
    .alloc_valid(alloc_valid),
    .alloc_reg  (alloc_reg),
    .rd_reg1    (rd_reg1),
    .rd_reg2    (rd_reg2),
    .stall      (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ptr_m   = 0;
    w_m     = 1'b0;
    wreg_m  = '0;
    wdata_m = '0;
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
  endtask

  // One clock: check combinational outputs, clock, update model, check registers.
  task automatic step(input string tag);
    int g;
    logic [4:0] r;
    #2;
    if (RST)                                           g = -1;
    else if (req0_valid && req1_valid)                 g = ptr_m;
    else if (req0_valid)                               g = 0;
    else if (req1_valid)                               g = 1;
    else                                               g = -1;
    chk({tag, ".ready0"}, {31'b0, req0_ready}, {31'b0, g == 0});
    chk({tag, ".ready1"}, {31'b0, req1_ready}, {31'b0, g == 1});
    chk({tag, ".stall"},  {31'b0, stall},
        {31'b0, SB_EN && (busy_m[rd_reg1] || busy_m[rd_reg2])});
    @(posedge CLK);
    if (RST) begin
      model_reset();
    end else begin
      w_m = 1'b0;
      if (g >= 0) begin
        r = (g == 1) ? req1_reg : req0_reg;
        if (r != 0) begin
          w_m     = 1'b1;
          wreg_m  = r;
          wdata_m = (g == 1) ? req1_data : req0_data;
          busy_m[r] = 1'b0;
        end
        ptr_m = 1 - g;
      end
      if (alloc_valid && alloc_reg != 0) busy_m[alloc_reg] = 1'b1;
    end
    g_last = g;
    #1;
    chk({tag, ".W"},      {31'b0, W},     {31'b0, w_m});
    chk({tag, ".W_reg"},  {27'b0, W_reg}, {27'b0, wreg_m});
    chk({tag, ".W_data"}, W_data,         wdata_m);
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; alloc_valid = 0;
    req0_reg = '0; req1_reg = '0; req0_data = '0; req1_data = '0;
    alloc_reg = '0; rd_reg1 = '0; rd_reg2 = '0;
  endtask

  initial begin
    RST = 1'b1;
    idle_inputs();
    // Initial reset edge: DUT state is unknown before it, so no checks yet.
    @(posedge CLK);
    model_reset();
    #1;
    step("reset");
    RST = 1'b0;

    // Single requester
    req0_valid = 1; req0_reg = 5'd5; req0_data = 32'h1234;
    step("single");
    chk("single.W_reg5", {27'b0, W_reg}, 32'd5);
    req0_valid = 0;
    step("single_idle");

    // Contention from a fresh pointer: grants 0,1,0,1
    RST = 1; step("ctn_rst"); RST = 0;
    req0_valid = 1; req0_reg = 5'd3; req0_data = 32'hA;
    req1_valid = 1; req1_reg = 5'd4; req1_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      step("contention");
      chk("contention.seq", {27'b0, W_reg}, (i % 2 == 0) ? 32'd3 : 32'd4);
    end
    idle_inputs();
    step("ctn_idle");

    // Zero register: accepted, discarded
    req1_valid = 1; req1_reg = 5'd0; req1_data = 32'hFFFF; rd_reg1 = 5'd0;
    step("zero");
    req1_valid = 0;
    step("zero_after");

    // Scoreboard lifecycle
    alloc_valid = 1; alloc_reg = 5'd7;
    step("sb_alloc");
    alloc_valid = 0; rd_reg1 = 5'd7;
    step("sb_pending");
    req0_valid = 1; req0_reg = 5'd7; req0_data = 32'hC0DE;
    step("sb_write");
    req0_valid = 0;
    step("sb_cleared");

    // Set/clear collision
    alloc_valid = 1; alloc_reg = 5'd9;
    req0_valid = 1; req0_reg = 5'd9; req0_data = 32'h99;
    step("collide");
    idle_inputs(); rd_reg2 = 5'd9;
    step("collide_after");

    // Reset mid-operation with busy[7] set
    alloc_valid = 1; alloc_reg = 5'd7;
    step("mid_alloc");
    alloc_valid = 0; rd_reg1 = 5'd7;
    req0_valid = 1; req0_reg = 5'd1; req0_data = 32'h11;
    req1_valid = 1; req1_reg = 5'd2; req1_data = 32'h22;
    RST = 1;
    step("mid_rst");
    RST = 0;
    step("mid_after");
    idle_inputs();
    step("mid_idle");

    // Random traffic; each requester holds its request until granted
    req0_valid = 1'($urandom); req0_reg = 5'($urandom_range(0, 7)); req0_data = $urandom;
    req1_valid = 1'($urandom); req1_reg = 5'($urandom_range(0, 7)); req1_data = $urandom;
    for (int n = 0; n < 400; n++) begin
      RST         = ($urandom_range(0, 39) == 0);
      alloc_valid = 1'($urandom);
      alloc_reg   = 5'($urandom_range(0, 7));
      rd_reg1     = 5'($urandom_range(0, 7));
      rd_reg2     = 5'($urandom_range(0, 7));
      step("rand");
      if (!req0_valid || g_last == 0) begin
        req0_valid = 1'($urandom); req0_reg = 5'($urandom_range(0, 7)); req0_data = $urandom;
      end
      if (!req1_valid || g_last == 1) begin
        req1_valid = 1'($urandom); req1_reg = 5'($urandom_range(0, 7)); req1_data = $urandom;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
